// File: rtl/imm_gen_pipe_if.sv
// Decode-stage immediate generator bus: request {instr, immsel, tag} in, extended immediate out.
// The master drives requests and out_ready; the slave (the generator) answers.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_immsel;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_immsel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_immsel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator, one-cycle latency; a main + skid register pair gives full
// throughput, and in_ready depends only on skid occupancy. IMMGEN_ZICSR_EN enables CSR uimm (sel 110).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_I    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_B    = 3'b011;
  localparam logic [2:0] SEL_J    = 3'b100;
  localparam logic [2:0] SEL_U    = 3'b101;
  localparam logic [2:0] SEL_CSR  = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } meta_t;

  meta_t       dec;
  meta_t       main_q;
  meta_t       skid_q;
  logic        main_valid;
  logic        skid_valid;
  logic        accept;
  logic        drain;
  logic [31:0] instr;
  logic        unused_opcode;

  assign instr         = bus.in_instr;
  assign unused_opcode = &{1'b0, instr[6:0]};

  always_comb begin
    dec         = '0;
    dec.tag     = bus.in_tag;
    dec.illegal = 1'b0;
    case (bus.in_immsel)
      SEL_NONE: dec.imm = '0;
      SEL_I:    dec.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      SEL_S:    dec.imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      SEL_B:    dec.imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      SEL_J:    dec.imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      SEL_U:    dec.imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
`ifdef IMMGEN_ZICSR_EN
      SEL_CSR:  dec.imm = {{(XLEN-5){1'b0}}, instr[19:15]};
`else
      SEL_CSR:  dec.illegal = 1'b1;
`endif
      default:  dec.illegal = 1'b1;
    endcase
  end

  assign accept = bus.in_valid & ~skid_valid;
  assign drain  = ~main_valid | bus.out_ready;

  // Skid only fills while main is stalled; it always empties into main first, keeping FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_q <= dec;
        end
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = ~skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share clk/rst/flush.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [4:0] tag);
    b32.in_valid  = v;
    b32.in_instr  = ins;
    b32.in_immsel = sel;
    b32.in_tag    = tag;
  endtask

  // Fill main (tag a) and skid (tag b) while the consumer stalls.
  task automatic fill_both(input logic [4:0] a, input logic [4:0] b);
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'b001, a);
    tick();
    drive32(1'b1, 32'h00500093, 3'b001, b);
    tick();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", b32.out_valid); end
    vectors++; if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", b32.in_ready); end
    vectors++; if (b32.out_imm !== 32'h0) begin miscompares++; $display("FAIL rst_out_imm: got %h want 0", b32.out_imm); end
    vectors++; if (b32.out_tag !== 5'd0) begin miscompares++; $display("FAIL rst_out_tag: got %0d want 0", b32.out_tag); end
    vectors++; if (b32.out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_out_illegal: got %b want 0", b32.out_illegal); end
    vectors++; if (b64.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst64_out_valid: got %b want 0", b64.out_valid); end
  endtask

  task automatic test_itype();
    b32.out_ready = 1'b1;
    drive32(1'b1, 32'hFFF00093, 3'b001, 5'd3);
    tick();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    vectors++; if (b32.out_valid !== 1'b1) begin miscompares++; $display("FAIL itype_valid: got %b want 1", b32.out_valid); end
    vectors++; if (b32.out_imm !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL itype_imm: got %h want ffffffff", b32.out_imm); end
    vectors++; if (b32.out_illegal !== 1'b0) begin miscompares++; $display("FAIL itype_illegal: got %b want 0", b32.out_illegal); end
    vectors++; if (b32.out_tag !== 5'd3) begin miscompares++; $display("FAIL itype_tag: got %0d want 3", b32.out_tag); end
    tick();
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL itype_drained: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [6];
    logic [2:0]  sel [6];
    logic [31:0] exp [6];
    ins[0] = 32'hFE112E23; sel[0] = 3'b010; exp[0] = 32'hFFFFFFFC;
    ins[1] = 32'h0080006F; sel[1] = 3'b100; exp[1] = 32'h00000008;
    ins[2] = 32'hFFDFF06F; sel[2] = 3'b100; exp[2] = 32'hFFFFFFFC;
    ins[3] = 32'h123450B7; sel[3] = 3'b101; exp[3] = 32'h12345000;
    ins[4] = 32'hFFF00093; sel[4] = 3'b000; exp[4] = 32'h00000000;
    ins[5] = 32'h00500093; sel[5] = 3'b001; exp[5] = 32'h00000005;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive32(1'b1, ins[i], sel[i], 5'(i + 10));
      tick();
      vectors++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'(i + 10)) begin miscompares++; $display("FAIL b2b_order[%0d]: got valid %b tag %0d want valid 1 tag %0d", i, b32.out_valid, b32.out_tag, i + 10); end
      vectors++; if (b32.out_imm !== exp[i]) begin miscompares++; $display("FAIL b2b_imm[%0d]: got %h want %h", i, b32.out_imm, exp[i]); end
      vectors++; if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, b32.in_ready); end
    end
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    tick();
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [3];
    logic [2:0]  sel [3];
    logic [63:0] exp [3];
    ins[0] = 32'h800000B7; sel[0] = 3'b101; exp[0] = 64'hFFFFFFFF80000000;
    ins[1] = 32'h123450B7; sel[1] = 3'b101; exp[1] = 64'h0000000012345000;
    ins[2] = 32'hFE000EE3; sel[2] = 3'b011; exp[2] = 64'hFFFFFFFFFFFFFFFC;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b64.in_valid  = 1'b1;
      b64.in_instr  = ins[i];
      b64.in_immsel = sel[i];
      b64.in_tag    = 5'(i + 20);
      tick();
      vectors++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'(i + 20)) begin miscompares++; $display("FAIL x64_order[%0d]: got valid %b tag %0d want valid 1 tag %0d", i, b64.out_valid, b64.out_tag, i + 20); end
      vectors++; if (b64.out_imm !== exp[i]) begin miscompares++; $display("FAIL x64_imm[%0d]: got %h want %h", i, b64.out_imm, exp[i]); end
    end
    b64.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    fill_both(5'd1, 5'd2);
    vectors++; if (b32.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_low: got %b want 0", b32.in_ready); end
    vectors++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd1) begin miscompares++; $display("FAIL bp_head: got valid %b tag %0d want valid 1 tag 1", b32.out_valid, b32.out_tag); end
    tick();
    vectors++; if (b32.out_tag !== 5'd1 || b32.out_imm !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL bp_stable: got tag %0d imm %h want tag 1 imm ffffffff", b32.out_tag, b32.out_imm); end
    b32.out_ready = 1'b1;
    tick();
    vectors++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd2) begin miscompares++; $display("FAIL bp_second: got valid %b tag %0d want valid 1 tag 2", b32.out_valid, b32.out_tag); end
    vectors++; if (b32.out_imm !== 32'h00000005) begin miscompares++; $display("FAIL bp_second_imm: got %h want 00000005", b32.out_imm); end
    vectors++; if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_back: got %b want 1", b32.in_ready); end
    tick();
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_flush();
    fill_both(5'd4, 5'd5);
    flush = 1'b1;
    drive32(1'b1, 32'hFFF00093, 3'b001, 5'd6);
    tick();
    flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    b32.out_ready = 1'b1;
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", b32.out_valid); end
    vectors++; if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", b32.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_emerge[%0d]: got %b want 0", i, b32.out_valid); end
    end
    // Empty pipe: the accept presented with flush must be discarded.
    flush = 1'b1;
    drive32(1'b1, 32'hFFF00093, 3'b001, 5'd7);
    tick();
    flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_accept_dropped: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_illegal();
    b32.out_ready = 1'b1;
    drive32(1'b1, 32'hFFF00093, 3'b111, 5'd8);
    tick();
    vectors++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h0) begin miscompares++; $display("FAIL ill111_imm: got valid %b imm %h want valid 1 imm 0", b32.out_valid, b32.out_imm); end
    vectors++; if (b32.out_illegal !== 1'b1) begin miscompares++; $display("FAIL ill111_flag: got %b want 1", b32.out_illegal); end
    drive32(1'b1, 32'h3400D073, 3'b110, 5'd9);
    tick();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
`ifdef IMMGEN_ZICSR_EN
    vectors++; if (b32.out_imm !== 32'h1) begin miscompares++; $display("FAIL csr_imm: got %h want 00000001", b32.out_imm); end
    vectors++; if (b32.out_illegal !== 1'b0) begin miscompares++; $display("FAIL csr_flag: got %b want 0", b32.out_illegal); end
`else
    vectors++; if (b32.out_imm !== 32'h0) begin miscompares++; $display("FAIL csr_imm: got %h want 00000000", b32.out_imm); end
    vectors++; if (b32.out_illegal !== 1'b1) begin miscompares++; $display("FAIL csr_flag: got %b want 1", b32.out_illegal); end
`endif
    tick();
  endtask

  task automatic test_reset_midstream();
    fill_both(5'd11, 5'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_out_valid: got %b want 0", b32.out_valid); end
    vectors++; if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_in_ready: got %b want 1", b32.in_ready); end
    vectors++; if (b32.out_imm !== 32'h0 || b32.out_tag !== 5'd0 || b32.out_illegal !== 1'b0) begin miscompares++; $display("FAIL mrst_data: got imm %h tag %0d ill %b want 0 0 0", b32.out_imm, b32.out_tag, b32.out_illegal); end
    b32.out_ready = 1'b1;
    drive32(1'b1, 32'h00500093, 3'b001, 5'd13);
    tick();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    vectors++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd13) begin miscompares++; $display("FAIL mrst_push: got valid %b tag %0d want valid 1 tag 13", b32.out_valid, b32.out_tag); end
    tick();
    vectors++; if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_drained: got %b want 0", b32.out_valid); end
  endtask

  initial begin
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    b32.out_ready = 1'b1;
    b64.in_valid  = 1'b0;
    b64.in_instr  = 32'h0;
    b64.in_immsel = 3'b000;
    b64.in_tag    = 5'd0;
    b64.out_ready = 1'b1;
    test_reset();
    test_itype();
    test_back_to_back();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
